// File: rtl/shift_pkg.sv
// Shared types and constants for the shift sequencer and its logical shifter core.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT2 = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int DATA_W_DEF = 32;

    // Amount width carries one extra MSB that flags an amount >= DATA_W.
    function automatic int amt_w(input int dw);
        return $clog2(dw) + 1;
    endfunction

endpackage

// File: rtl/shift_core.sv
// Combinational log2(DATA_W)-stage logical barrel shifter; vacated bits are zero.
module shift_core
    import shift_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SH_W   = $clog2(DATA_W)
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic              dir_i,
    input  logic [SH_W-1:0]   sh_i,
    output logic [DATA_W-1:0] res_o
);

    logic [DATA_W-1:0] acc;

    always_comb begin
        acc = data_i;
        for (int i = 0; i < SH_W; i++) begin
            if (sh_i[i]) begin
                acc = (dir_i == DIR_RIGHT) ? (acc >> (1 << i)) : (acc << (1 << i));
            end
        end
        res_o = acc;
    end

endmodule

// File: rtl/shift_sequencer.sv
// Valid/ready front end for the logical barrel shifter with a registered, held result.
// Define SHSEQ_ROTATE_EN to build rotates from two core passes on consecutive cycles.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AMT_W  = amt_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_dir,
    input  logic [AMT_W-1:0]  in_amt,
    input  logic              in_rot,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    localparam int SH_W = AMT_W - 1;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              accept;
    logic [DATA_W-1:0] core_data, core_res, load_res;
    logic              core_dir;
    logic [SH_W-1:0]   core_sh;

    // out_ready feeds in_ready combinationally so a consumed result frees the slot same cycle.
    assign in_ready  = (state_q == IDLE) | ((state_q == HOLD) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign out_data  = data_q;

    shift_core #(
        .DATA_W (DATA_W),
        .SH_W   (SH_W)
    ) u_core (
        .data_i (core_data),
        .dir_i  (core_dir),
        .sh_i   (core_sh),
        .res_o  (core_res)
    );

`ifdef SHSEQ_ROTATE_EN
    logic [DATA_W-1:0] part_q, part_d, op_q, op_d;
    logic              dir_q, dir_d;
    logic [SH_W-1:0]   n_q, n_d;
    logic              rot_start;

    // Rotate amount is taken modulo DATA_W; a zero rotate is a plain pass-through.
    assign rot_start = in_rot & (in_amt[SH_W-1:0] != '0);
    assign load_res  = (in_rot | ~in_amt[AMT_W-1]) ? core_res : '0;

    always_comb begin
        core_data = in_data;
        core_dir  = in_dir;
        core_sh   = in_amt[SH_W-1:0];
        if (state_q == ROT2) begin
            core_data = op_q;
            core_dir  = ~dir_q;
            core_sh   = ~n_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        part_q <= part_d;
        op_q   <= op_d;
        dir_q  <= dir_d;
        n_q    <= n_d;
    end
`else
    logic unused_rot;

    assign unused_rot = in_rot;
    assign load_res   = in_amt[AMT_W-1] ? '0 : core_res;
    assign core_data  = in_data;
    assign core_dir   = in_dir;
    assign core_sh    = in_amt[SH_W-1:0];
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
`ifdef SHSEQ_ROTATE_EN
        part_d  = part_q;
        op_d    = op_q;
        dir_d   = dir_q;
        n_d     = n_q;
`endif
        case (state_q)
            IDLE, HOLD: begin
                if (accept) begin
`ifdef SHSEQ_ROTATE_EN
                    if (rot_start) begin
                        state_d = ROT2;
                        part_d  = core_res;
                        op_d    = in_data;
                        dir_d   = in_dir;
                        n_d     = in_amt[SH_W-1:0];
                    end else begin
                        state_d = HOLD;
                        data_d  = load_res;
                    end
`else
                    state_d = HOLD;
                    data_d  = load_res;
`endif
                end else if ((state_q == HOLD) && out_ready) begin
                    state_d = IDLE;
                end
            end
`ifdef SHSEQ_ROTATE_EN
            ROT2: begin
                state_d = HOLD;
                data_d  = part_q | core_res;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

endmodule
